// File: rtl/debounced_key_pio_pkg.sv
// Shared register map and sizing helper for the debounced key PIO.
package debounced_key_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

  // Counter width able to hold DEBOUNCE_CYCLES: ceil(log2(cycles+1)).
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One input channel: 2-flop synchronizer followed by a stable-count debouncer.
module key_debounce_cell
  import debounced_key_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic sync_bit,
  output logic db_bit
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous key level into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
    end else begin
      meta_q <= in_bit;
      sync_q <= meta_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q  <= RESET_LEVEL;
      cnt_q <= '0;
    end else if (sync_q == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      db_q  <= sync_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign sync_bit = sync_q;
  assign db_bit   = db_q;

endmodule

// File: rtl/debounced_key_pio.sv
// Memory-mapped PIO for bouncing keys: debounced level, raw level,
// edge capture with per-bit rise/fall enables, and a masked level interrupt.
module debounced_key_pio
  import debounced_key_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .in_bit   (in_port[i]),
      .sync_bit (sync_q[i]),
      .db_bit   (db_q[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign rise         = db_q & ~db_prev;
  assign fall         = ~db_q & db_prev;
  assign edge_evt     = (rise & rise_en) | (fall & fall_en);
  assign cap_clr      = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = &{1'b0, writedata};

  // Delay the debounced level one cycle for edge detection; reset matches db_q so no edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) db_prev <= RESET_LEVEL;
    else       db_prev <= db_q;
  end

  // Software-writable mask and edge-enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '1;
    end else if (wr_en) begin
      case (address)
        ADDR_IRQ_MASK: irq_mask <= writedata[WIDTH-1:0];
        ADDR_RISE_EN:  rise_en  <= writedata[WIDTH-1:0];
        ADDR_FALL_EN:  fall_en  <= writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Sticky edge flags, write-1-to-clear; a simultaneous new edge wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) edge_capture <= '0;
    else       edge_capture <= (edge_capture & ~cap_clr) | edge_evt;
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux = db_q;
      ADDR_RAW:      rd_mux = sync_q;
      ADDR_IRQ_MASK: rd_mux = irq_mask;
      ADDR_EDGE_CAP: rd_mux = edge_capture;
      ADDR_RISE_EN:  rd_mux = rise_en;
      ADDR_FALL_EN:  rd_mux = fall_en;
      default:       rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= 32'(rd_mux);
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: doc/debounced_key_pio.md
DEBOUNCED_KEY_PIO -- requirements
Module: debounced_key_pio

Interface
REQ-001 Parameter WIDTH, default 4, number of input channels, legal 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), consecutive stable cycles required to accept a level change, legal >= 1.
REQ-003 Parameter RESET_LEVEL, default all ones, WIDTH bits, the idle level of the inputs (all ones suits active-low keys).
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  3  register select.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous key/switch inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 Each in_port bit SHALL pass through a 2-flop synchronizer (sync_q) before any other use.
REQ-014 Each channel SHALL hold a debounced level db_q and a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-015 Counter behaviour: it SHALL clear when sync_q equals db_q and increment when they differ; db_q SHALL take sync_q, and the counter SHALL clear, on the edge that ends the DEBOUNCE_CYCLES-th consecutive differing cycle.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output SHALL NOT change db_q.
REQ-017 Edge detect: rise[i] = db_q[i] & ~db_prev[i]; fall[i] = ~db_q[i] & db_prev[i]; db_prev SHALL be db_q delayed one cycle.
REQ-018 edge_capture[i] SHALL set on (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
REQ-019 Register map (read): 0 = db_q; 1 = sync_q (raw); 2 = irq_mask; 3 = edge_capture; 4 = rise_en; 5 = fall_en; 6 and 7 = zero.
REQ-020 Writes take effect when chipselect=1 and write_n=0: address 2, 4 and 5 load writedata[WIDTH-1:0]; address 3 clears each edge_capture bit whose writedata bit is 1 (write-1-to-clear); writes to addresses 0, 1, 6 and 7 are ignored.
REQ-021 If an edge event and a clear on the same bit occur in the same cycle, the set SHALL win.
REQ-022 readdata SHALL update every cycle from address, regardless of chipselect, with 1-cycle latency; bits 31:WIDTH read zero.
REQ-023 irq SHALL be |(edge_capture & irq_mask), derived combinationally from registers only.
REQ-024 Latency: a clean in_port step at cycle 0 updates db_q at cycle 2+DEBOUNCE_CYCLES and sets edge_capture (and irq, if masked in) at cycle 3+DEBOUNCE_CYCLES.
REQ-025 A rise_en/fall_en change SHALL NOT by itself set edge_capture.

Reset
REQ-026 On reset: sync_q, db_q and db_prev = RESET_LEVEL; counters = 0; edge_capture = 0; irq_mask = 0; rise_en = 0; fall_en = all ones; readdata = 0; irq = 0.
REQ-027 A reset asserted mid-debounce SHALL discard the partial count, and no edge SHALL be captured on the first cycle after reset.

Structure
REQ-028 Register address constants (ADDR_DATA .. ADDR_FALL_EN) SHALL live in the shared package debounced_key_pio_pkg.
REQ-029 The per-channel synchronizer, counter and db_q logic SHALL be one sub-module, key_debounce_cell, instantiated WIDTH times via generate.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=4'hF)
REQ-030 Reset, then read address 5 -> readdata=0x0000000F; read address 0 -> 0x0000000F; irq=0.
REQ-031 Drive in_port[0]=0 and hold -> db_q[0]=0 at cycle 6, edge_capture=0x1 at cycle 7; with irq_mask=0x1, irq=1 at cycle 7.
REQ-032 Pulse in_port[1] low for 3 cycles -> db_q, edge_capture and irq unchanged.
REQ-033 Write rise_en=0x4, then release in_port[2] from 0 to 1 -> edge_capture bit 2 set; a later fall on bit 2 with fall_en bit 2 cleared -> no set.
REQ-034 edge_capture=0x3; write 0x1 to address 3 -> edge_capture=0x2; a clear of bit 1 in the same cycle as a new bit-1 edge -> bit 1 stays 1.
REQ-035 Assert reset while a bit-3 counter is at 3 -> after reset db_q=0xF, counter=0, edge_capture=0.
